// File: rtl/glitch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : glitch_sequencer_if
// Description : Control, configuration and status bundle between the host-side
//               register logic and the glitch timing sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface glitch_sequencer_if #(
    parameter int DELAY_W = 16,
    parameter int WIDTH_W = 8,
    parameter int COUNT_W = 4
);
    logic               arm;
    logic               abort;
    logic               trig_in;
    logic               trig_edge;
    logic [DELAY_W-1:0] cfg_delay;
    logic [WIDTH_W-1:0] cfg_width;
    logic [WIDTH_W-1:0] cfg_gap;
    logic [COUNT_W-1:0] cfg_count;
    logic               glitch_out;
    logic               armed;
    logic               busy;
    logic               done;
    logic [COUNT_W-1:0] pulse_idx;

    modport master (
        output arm, abort, trig_in, trig_edge,
        output cfg_delay, cfg_width, cfg_gap, cfg_count,
        input  glitch_out, armed, busy, done, pulse_idx
    );

    modport slave (
        input  arm, abort, trig_in, trig_edge,
        input  cfg_delay, cfg_width, cfg_gap, cfg_count,
        output glitch_out, armed, busy, done, pulse_idx
    );
endinterface
`default_nettype wire

// File: rtl/glitch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : glitch_sequencer
// Description : Arms on request, waits for a selected trigger edge, then emits
//               a delayed burst of programmable-width glitch pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module glitch_sequencer #(
    parameter int DELAY_W     = 16,
    parameter int WIDTH_W     = 8,
    parameter int COUNT_W     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  wire              clk,
    input  wire              rst,
    glitch_sequencer_if.slave bus
);

    localparam logic [DELAY_W-1:0] c_D_ONE = DELAY_W'(1);
    localparam logic [WIDTH_W-1:0] c_W_ONE = WIDTH_W'(1);
    localparam logic [COUNT_W-1:0] c_C_ONE = COUNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_DELAY = 3'd2,
        S_PULSE = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                 r_prev;
    logic [DELAY_W-1:0]   r_delay;
    logic [WIDTH_W-1:0]   r_width;
    logic [WIDTH_W-1:0]   r_gap;
    logic [COUNT_W-1:0]   r_count;
    logic                 r_edge;
    logic [DELAY_W-1:0]   r_dcnt;
    logic [WIDTH_W-1:0]   r_wcnt;
    logic [COUNT_W-1:0]   r_idx;
    logic                 r_glitch;
    logic                 r_armed;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_sync_last;
    logic                 w_strobe;
    logic [WIDTH_W-1:0]   w_width_m1;
    logic [WIDTH_W-1:0]   w_gap_m1;
    logic [COUNT_W-1:0]   w_last_idx;

    // Synchronizer chain for the asynchronous trigger input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync[0] <= 1'b0;
        end else begin
            r_sync[0] <= bus.trig_in;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync[gi] <= 1'b0;
                end else begin
                    r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_sync_last;
        end
    end

    assign w_sync_last = r_sync[SYNC_STAGES-1];
    assign w_strobe    = r_edge ? (r_prev & ~w_sync_last) : (w_sync_last & ~r_prev);

    // Zero-valued width, gap and count fields behave as one
    assign w_width_m1 = (r_width == '0) ? '0 : r_width - c_W_ONE;
    assign w_gap_m1   = (r_gap   == '0) ? '0 : r_gap   - c_W_ONE;
    assign w_last_idx = (r_count == '0) ? '0 : r_count - c_C_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_delay  <= '0;
            r_width  <= '0;
            r_gap    <= '0;
            r_count  <= '0;
            r_edge   <= 1'b0;
            r_dcnt   <= '0;
            r_wcnt   <= '0;
            r_idx    <= '0;
            r_glitch <= 1'b0;
            r_armed  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.abort) begin
                r_state  <= S_IDLE;
                r_glitch <= 1'b0;
                r_armed  <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.arm) begin
                            r_delay <= bus.cfg_delay;
                            r_width <= bus.cfg_width;
                            r_gap   <= bus.cfg_gap;
                            r_count <= bus.cfg_count;
                            r_edge  <= bus.trig_edge;
                            r_idx   <= '0;
                            r_armed <= 1'b1;
                            r_state <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (w_strobe) begin
                            r_dcnt  <= r_delay;
                            r_armed <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= S_DELAY;
                        end
                    end
                    // Down-count to zero gives D+1 cycles without wrapping at max D
                    S_DELAY: begin
                        if (r_dcnt == '0) begin
                            r_wcnt   <= w_width_m1;
                            r_glitch <= 1'b1;
                            r_state  <= S_PULSE;
                        end else begin
                            r_dcnt <= r_dcnt - c_D_ONE;
                        end
                    end
                    S_PULSE: begin
                        if (r_wcnt == '0) begin
                            r_glitch <= 1'b0;
                            if (r_idx == w_last_idx) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_wcnt  <= w_gap_m1;
                                r_state <= S_GAP;
                            end
                        end else begin
                            r_wcnt <= r_wcnt - c_W_ONE;
                        end
                    end
                    S_GAP: begin
                        if (r_wcnt == '0) begin
                            r_idx    <= r_idx + c_C_ONE;
                            r_wcnt   <= w_width_m1;
                            r_glitch <= 1'b1;
                            r_state  <= S_PULSE;
                        end else begin
                            r_wcnt <= r_wcnt - c_W_ONE;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_glitch <= 1'b0;
                        r_armed  <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.glitch_out = r_glitch;
    assign bus.armed      = r_armed;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pulse_idx  = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_glitch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_glitch_sequencer
// Description : Scoreboard bench for glitch_sequencer; per-cycle expectations
//               are derived from the trigger-relative burst timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glitch_sequencer;

    localparam int DW = 16;
    localparam int WW = 8;
    localparam int CW = 4;
    localparam int SS = 2;

    typedef struct {
        logic          g;
        logic          b;
        logic          d;
        logic          a;
        logic [CW-1:0] idx;
        bit            chk_b;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    glitch_sequencer_if #(.DELAY_W(DW), .WIDTH_W(WW), .COUNT_W(CW)) bus ();

    glitch_sequencer #(
        .DELAY_W    (DW),
        .WIDTH_W    (WW),
        .COUNT_W    (CW),
        .SYNC_STAGES(SS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_quiet(input string tag, input logic exp_armed);
        check_eq({tag, "_armed"}, bus.armed, exp_armed);
        check_eq({tag, "_busy"}, bus.busy, 1'b0);
        check_eq({tag, "_glitch"}, bus.glitch_out, 1'b0);
        check_eq({tag, "_done"}, bus.done, 1'b0);
    endtask

    task automatic do_arm(input int d, input int w, input int g, input int c, input bit e);
        bus.cfg_delay = DW'(d);
        bus.cfg_width = WW'(w);
        bus.cfg_gap   = WW'(g);
        bus.cfg_count = CW'(c);
        bus.trig_edge = e;
        bus.arm       = 1'b1;
        tick();
        bus.arm       = 1'b0;
        check_quiet("arm", 1'b1);
        check_eq("arm_idx", bus.pulse_idx, '0);
    endtask

    // Trigger, then compare every cycle against the burst timing model.
    // kill_m >= 0 applies abort (or rst) sampled at edge k+kill_m.
    task automatic burst(input int d, input int w, input int g, input int c, input bit e,
                         input bit perturb, input int kill_m, input bit kill_rst);
        int   wp, gp, cp, start, period, fin, last, rel, idx;
        bit   killed, in_pulse;
        logic act, idle;
        exp_t x;
        wp     = (w == 0) ? 1 : w;
        gp     = (g == 0) ? 1 : g;
        cp     = (c == 0) ? 1 : c;
        start  = SS + 1 + d;
        period = wp + gp;
        fin    = start + cp * wp + (cp - 1) * gp;
        last   = fin + 2;
        act    = e ? 1'b0 : 1'b1;
        idle   = ~act;
        for (int m = 0; m <= last; m++) begin
            killed   = (kill_m >= 0) && (m >= kill_m);
            in_pulse = 1'b0;
            idx      = 0;
            if (m >= start && m < fin) begin
                rel      = m - start;
                idx      = rel / period;
                in_pulse = (rel % period) < wp;
            end else if (m >= fin) begin
                idx = cp - 1;
            end
            x.g     = !killed && in_pulse;
            x.a     = !killed && (m < SS);
            x.b     = !killed && (m >= SS) && (m < fin);
            x.d     = !killed && (m == fin);
            x.idx   = killed ? '0 : CW'(idx);
            x.chk_b = (m != SS);
            sb.push_back(x);
        end
        bus.trig_in = act;
        for (int m = 0; m <= last; m++) begin
            rst       = kill_rst && (m == kill_m);
            bus.abort = !kill_rst && (m == kill_m);
            if (perturb) begin
                if (m == 0)    begin bus.arm = 1'b1; bus.cfg_width = 8'd7; bus.cfg_delay = 16'd9; end
                if (m == 1)    bus.arm = 1'b0;
                if (m == 3)    begin bus.arm = 1'b1; bus.trig_in = idle; end
                if (m == 4)    begin bus.arm = 1'b0; bus.trig_in = act; end
                if (m == 8)    bus.trig_in = idle;
                if (m == 9)    begin bus.arm = 1'b1; bus.trig_in = act; end
                if (m == 10)   bus.arm = 1'b0;
                if (m == fin + 1) bus.arm = 1'b1;
                if (m == fin + 2) bus.arm = 1'b0;
            end
            tick();
            x = sb.pop_front();
            check_eq("glitch_out", bus.glitch_out, x.g);
            check_eq("armed", bus.armed, x.a);
            check_eq("done", bus.done, x.d);
            check_eq("pulse_idx", bus.pulse_idx, x.idx);
            if (x.chk_b) check_eq("busy", bus.busy, x.b);
        end
        rst         = 1'b0;
        bus.abort   = 1'b0;
        bus.arm     = 1'b0;
        bus.trig_in = idle;
        repeat (SS + 2) tick();
    endtask

    initial begin
        rst           = 1'b1;
        bus.arm       = 1'b0;
        bus.abort     = 1'b0;
        bus.trig_in   = 1'b0;
        bus.trig_edge = 1'b0;
        bus.cfg_delay = '0;
        bus.cfg_width = '0;
        bus.cfg_gap   = '0;
        bus.cfg_count = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_quiet("reset", 1'b0);
        check_eq("reset_idx", bus.pulse_idx, '0);

        // abort and arm together: abort wins
        bus.abort = 1'b1;
        bus.arm   = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.arm   = 1'b0;
        check_quiet("abort_arm", 1'b0);

        // basic single pulse
        do_arm(5, 3, 0, 1, 1'b0);
        burst(5, 3, 0, 1, 1'b0, 1'b0, -1, 1'b0);

        // multi-pulse burst
        do_arm(0, 2, 4, 3, 1'b0);
        burst(0, 2, 4, 3, 1'b0, 1'b0, -1, 1'b0);

        // falling-edge mode: a rising edge while armed must not fire
        do_arm(4, 2, 1, 2, 1'b1);
        bus.trig_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_quiet("fall_rise_ignored", 1'b1);
        end
        burst(4, 2, 1, 2, 1'b1, 1'b0, -1, 1'b0);
        bus.trig_in = 1'b0;
        repeat (SS + 2) tick();

        // abort mid-pulse, then a normal burst
        do_arm(0, 200, 1, 1, 1'b0);
        burst(0, 200, 1, 1, 1'b0, 1'b0, 50, 1'b0);
        do_arm(5, 3, 0, 1, 1'b0);
        burst(5, 3, 0, 1, 1'b0, 1'b0, -1, 1'b0);

        // ignore rules: unperturbed and perturbed runs share one expectation
        do_arm(3, 2, 3, 2, 1'b0);
        burst(3, 2, 3, 2, 1'b0, 1'b0, -1, 1'b0);
        do_arm(3, 2, 3, 2, 1'b0);
        burst(3, 2, 3, 2, 1'b0, 1'b1, -1, 1'b0);

        // strobe coinciding with arm, and trigger already high at arm
        bus.cfg_delay = 16'd1;
        bus.cfg_width = 8'd1;
        bus.cfg_gap   = 8'd1;
        bus.cfg_count = 4'd1;
        bus.trig_edge = 1'b0;
        bus.trig_in   = 1'b1;
        tick();
        tick();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_quiet("arm_strobe_ignored", 1'b1);
            tick();
        end
        bus.trig_in = 1'b0;
        repeat (SS + 2) tick();
        check_quiet("arm_strobe_wait", 1'b1);
        burst(1, 1, 1, 1, 1'b0, 1'b0, -1, 1'b0);

        // zero config: single one-cycle pulse
        do_arm(2, 0, 0, 0, 1'b0);
        burst(2, 0, 0, 0, 1'b0, 1'b0, -1, 1'b0);

        // reset during DELAY
        do_arm(100, 3, 1, 1, 1'b0);
        burst(100, 3, 1, 1, 1'b0, 1'b0, 20, 1'b1);

        // maximum delay
        do_arm(65535, 1, 1, 1, 1'b0);
        burst(65535, 1, 1, 1, 1'b0, 1'b0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
